// File: rtl/master_axi_test_pkg.sv
// Shared types and helpers for the master_axi_test AXI4-Stream loopback buffer.
// A stored beat is {tlast, tstrb, tdata}, packed MSB to LSB.
package master_axi_test_pkg;

   localparam int AXIS_DW = 32;
   localparam int AXIS_SW = AXIS_DW / 8;

   function automatic int beat_width(input int dw);
      return dw + dw / 8 + 1;
   endfunction

   typedef struct packed {
      logic                last;
      logic [AXIS_SW-1:0]  strb;
      logic [AXIS_DW-1:0]  data;
   } axis_beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on dout whenever the FIFO is not empty.
// The occupancy count is one bit wider than the pointers so that full and empty are distinguishable.
module axis_sync_fifo
   import master_axi_test_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = beat_width(AXIS_DW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/master_axi_test.sv
// AXI4-Stream loopback buffer: s00 beats are queued and replayed unchanged on m00,
// with m00 held idle for a programmable number of cycles after reset.
module master_axi_test
   import master_axi_test_pkg::*;
#(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_START_COUNT = 32,
   parameter int FIFO_DEPTH             = 16
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,
   input  logic                                  s00_axis_tvalid,
   output logic                                  s00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                                  m00_axis_tlast,
   output logic                                  m00_axis_tvalid,
   input  logic                                  m00_axis_tready
);

   localparam int DW = C_S00_AXIS_TDATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int BW = beat_width(DW);
   localparam logic [31:0] START_VAL = 32'(C_M00_AXIS_START_COUNT);

   if (C_M00_AXIS_TDATA_WIDTH != C_S00_AXIS_TDATA_WIDTH) begin : g_width_check
      $error("master_axi_test: source and sink data widths must match");
   end

   logic [31:0]   start_cnt;
   logic          started;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [BW-1:0] beat_in;
   logic [BW-1:0] head;

   assign started = (start_cnt == START_VAL);

   // Counts up once per cycle after reset and then parks, so started never drops back.
   always_ff @(posedge aclk) begin
      if (areset) begin
         start_cnt <= '0;
      end else if (!started) begin
         start_cnt <= start_cnt + 32'd1;
      end
   end

   assign s00_axis_tready = ~areset & ~fifo_full;
   assign m00_axis_tvalid = ~areset & started & ~fifo_empty;
   assign push            = s00_axis_tvalid & s00_axis_tready;
   assign pop             = m00_axis_tvalid & m00_axis_tready;
   assign beat_in         = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};

   axis_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BW)
   ) u_fifo (
      .clk   (aclk),
      .rst   (areset),
      .push  (push),
      .pop   (pop),
      .din   (beat_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Payload is forced to zero whenever no beat is being offered.
   assign m00_axis_tdata = m00_axis_tvalid ? head[DW-1:0]       : '0;
   assign m00_axis_tstrb = m00_axis_tvalid ? head[DW+SW-1:DW]   : '0;
   assign m00_axis_tlast = m00_axis_tvalid ? head[BW-1]         : 1'b0;

   a_source_stable : assert property (
      @(posedge aclk) disable iff (areset)
      (m00_axis_tvalid && !m00_axis_tready) |=>
         (m00_axis_tvalid && $stable(m00_axis_tdata) && $stable(m00_axis_tstrb) && $stable(m00_axis_tlast))
   );

endmodule

// File: tb/tb_master_axi_test.sv
// Scoreboard bench for master_axi_test: accepted sink beats queue expectations, a monitor checks m00.
module tb_master_axi_test;
   import master_axi_test_pkg::*;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] s00_tdata;
   logic [3:0]  s00_tstrb;
   logic        s00_tlast;
   logic        s00_tvalid;
   logic        s00_tready;
   logic [31:0] m00_tdata;
   logic [3:0]  m00_tstrb;
   logic        m00_tlast;
   logic        m00_tvalid;
   logic        m00_tready;

   axis_beat_t exp_q[$];
   axis_beat_t wr_beat;
   axis_beat_t mon_exp;
   int n_compared = 0;
   int n_mismatch = 0;
   int n_pop      = 0;

   always #5 aclk = ~aclk;

   master_axi_test dut (
      .aclk            (aclk),
      .areset          (areset),
      .s00_axis_tdata  (s00_tdata),
      .s00_axis_tstrb  (s00_tstrb),
      .s00_axis_tlast  (s00_tlast),
      .s00_axis_tvalid (s00_tvalid),
      .s00_axis_tready (s00_tready),
      .m00_axis_tdata  (m00_tdata),
      .m00_axis_tstrb  (m00_tstrb),
      .m00_axis_tlast  (m00_tlast),
      .m00_axis_tvalid (m00_tvalid),
      .m00_axis_tready (m00_tready)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every sink handshake becomes an expected source beat.
   always @(negedge aclk) begin
      if (!areset && s00_tvalid && s00_tready) begin
         wr_beat = {s00_tlast, s00_tstrb, s00_tdata};
         exp_q.push_back(wr_beat);
      end
   end

   // Every source handshake must match the oldest outstanding expectation.
   always @(negedge aclk) begin
      if (m00_tvalid && m00_tready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL unexpected_beat: got %0h, expected no beat at %0t",
                     {m00_tlast, m00_tstrb, m00_tdata}, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("m00_beat", 64'({m00_tlast, m00_tstrb, m00_tdata}), 64'(mon_exp));
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] d, input logic [3:0] s, input logic l);
      bit acc;
      int budget;
      s00_tdata  = d;
      s00_tstrb  = s;
      s00_tlast  = l;
      s00_tvalid = 1'b1;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
         @(negedge aclk);
         acc = s00_tready;
         @(posedge aclk);
         #1;
         budget++;
      end
      if (!acc) begin
         n_compared++;
         n_mismatch++;
         $display("[TB] FAIL push_timeout: beat %0h not accepted, required acceptance", d);
      end
   endtask

   task automatic idleSink();
      s00_tvalid = 1'b0;
      s00_tdata  = '0;
      s00_tstrb  = '0;
      s00_tlast  = 1'b0;
   endtask

   task automatic doReset(input int cycles);
      areset     = 1'b1;
      s00_tvalid = 1'b1;
      s00_tdata  = 32'hDEAD_BEEF;
      s00_tstrb  = 4'hF;
      s00_tlast  = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge aclk);
         checkOutput("reset_outputs",
                     64'({s00_tready, m00_tvalid, m00_tlast, m00_tstrb, m00_tdata}), 64'd0);
         @(posedge aclk);
         #1;
      end
      exp_q.delete();
      areset = 1'b0;
      idleSink();
   endtask

   task automatic checkDelay(input int n_valid);
      for (int i = 0; i < 32; i++) begin
         @(negedge aclk);
         checkOutput("startup_idle", 64'({m00_tvalid, m00_tlast, m00_tstrb, m00_tdata}), 64'd0);
      end
      for (int i = 0; i < n_valid; i++) begin
         @(negedge aclk);
         checkOutput("startup_valid", 64'(m00_tvalid), 64'd1);
      end
   endtask

   task automatic waitDrain(input string name, input int exp_pops);
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 300) begin
         @(posedge aclk);
         #1;
         budget++;
      end
      repeat (2) @(posedge aclk);
      #1;
      checkOutput({name, "_left"}, 64'(exp_q.size()), 64'd0);
      checkOutput({name, "_pops"}, 64'(n_pop), 64'(exp_pops));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int idx;
      bit acc;
      areset     = 1'b1;
      m00_tready = 1'b1;
      idleSink();

      // Reset with the sink pushing, then start-up delay with four early beats.
      doReset(3);
      n_pop = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) applyStimulus(32'(i), 4'hF, 1'b0);
            idleSink();
         end
         checkDelay(4);
      join
      @(posedge aclk);
      #1;
      waitDrain("startup", 4);

      // Continuous stream with tlast on every fourth beat.
      $display("[TB] stream phase");
      n_pop = 0;
      for (int i = 0; i < 32; i++) applyStimulus(32'(i), 4'h1, (i % 4) == 3);
      idleSink();
      waitDrain("stream", 32);

      // Backpressure: only the FIFO depth worth of beats gets in.
      $display("[TB] backpressure phase");
      n_pop      = 0;
      m00_tready = 1'b0;
      idx        = 0;
      for (int c = 0; c < 20; c++) begin
         s00_tdata  = 32'h1000 + 32'(idx);
         s00_tstrb  = 4'hF;
         s00_tlast  = (idx == 19);
         s00_tvalid = 1'b1;
         @(negedge aclk);
         acc = s00_tready;
         @(posedge aclk);
         #1;
         if (acc) idx++;
      end
      checkOutput("bp_accepted", 64'(idx), 64'd16);
      @(negedge aclk);
      checkOutput("bp_full_ready", 64'(s00_tready), 64'd0);
      @(posedge aclk);
      #1;
      m00_tready = 1'b1;
      for (int i = idx; i < 20; i++) applyStimulus(32'h1000 + 32'(i), 4'hF, i == 19);
      idleSink();
      waitDrain("backpressure", 20);

      // Simultaneous push and pop at half occupancy across the pointer wrap.
      $display("[TB] simultaneous phase");
      n_pop      = 0;
      m00_tready = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(32'd100 + 32'(i), 4'h3, 1'b0);
      m00_tready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         s00_tdata  = 32'd108 + 32'(k);
         s00_tstrb  = 4'h5;
         s00_tlast  = (k == 9);
         s00_tvalid = 1'b1;
         @(negedge aclk);
         checkOutput("simul_handshake", 64'({s00_tready, m00_tvalid}), 64'd3);
         @(posedge aclk);
         #1;
      end
      idleSink();
      waitDrain("simultaneous", 18);

      // Reset with buffered beats: old data is discarded and the delay restarts.
      $display("[TB] mid-stream reset phase");
      m00_tready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(32'd200 + 32'(i), 4'hF, 1'b0);
      idleSink();
      @(posedge aclk);
      #1;
      doReset(1);
      n_pop      = 0;
      m00_tready = 1'b1;
      fork
         begin
            applyStimulus(32'd300, 4'hF, 1'b0);
            applyStimulus(32'd301, 4'hF, 1'b1);
            idleSink();
         end
         checkDelay(2);
      join
      @(posedge aclk);
      #1;
      waitDrain("reset_restart", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
